// File: rtl/sram_write_queue.sv
// In-order write queue feeding the renderer slot of the SRAM controller.
// Optional constant-fill engine (screen clear / scroll blanking) is built when SRAM_FILL_EN is defined.
package sram_pkg;
    localparam int SRAM_ADDRESS_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH    = 16;

    typedef struct packed {
        logic [SRAM_ADDRESS_WIDTH-1:0] address;
        logic [SRAM_DATA_WIDTH-1:0]    dout;
        logic                          we_n;
        logic                          oe_n;
        logic                          den;
    } SramRequest_t;

    typedef struct packed {
        logic [SRAM_DATA_WIDTH-1:0] din;
        logic                       done;
    } SramResult_t;
endpackage

// state | meaning
// IDLE  | accepting writes, draining the FIFO
// DRAIN | fill latched, writes blocked, waiting for queued writes to finish
// FILL  | issuing fill words until the count is exhausted
module sram_write_queue
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [SRAM_ADDRESS_WIDTH-1:0] wr_address,
    input  logic [SRAM_DATA_WIDTH-1:0]    wr_data,
    input  logic                          fill_start,
    input  logic [SRAM_ADDRESS_WIDTH-1:0] fill_base,
    input  logic [SRAM_ADDRESS_WIDTH-1:0] fill_count,
    input  logic [SRAM_DATA_WIDTH-1:0]    fill_data,
    output logic                          fill_busy,
    output SramRequest_t                  sramRequest,
    input  SramResult_t                   sramResult,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int AW    = SRAM_ADDRESS_WIDTH;
    localparam int DW    = SRAM_DATA_WIDTH;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [AW-1:0]    addrMem [FIFO_DEPTH];
    logic [DW-1:0]    dataMem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   pendingNext;
    logic             fifoHasWord;
    logic             push;
    logic             pop;
    logic             writeOpen;
    logic             fillActive;
    logic [AW-1:0]    fillAddr;
    logic [DW-1:0]    fillData;
    logic             unusedResult;

    assign unusedResult = ^sramResult.din;

    assign fifoHasWord = (pending != '0);
    assign wr_ready    = (pending != DEPTH_CNT) && writeOpen;
    assign push        = wr_valid && wr_ready;
    assign pop         = fifoHasWord && sramResult.done;
    assign idle        = !fifoHasWord && writeOpen;

    always_comb begin
        pendingNext = pending;
        if (push && !pop) begin
            pendingNext = pending + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            pendingNext = pending - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            pending <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            pending <= pendingNext;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr] <= wr_address;
            dataMem[wrPtr] <= wr_data;
        end
    end

`ifdef SRAM_FILL_EN
    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    state_t        state;
    logic [AW-1:0] fillRemain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fill_busy  <= 1'b0;
            fillAddr   <= '0;
            fillRemain <= '0;
            fillData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start && (fill_count != '0)) begin
                        fillAddr   <= fill_base;
                        fillRemain <= fill_count;
                        fillData   <= fill_data;
                        fill_busy  <= 1'b1;
                        // Skip DRAIN when nothing is left queued after this edge.
                        state      <= (pendingNext == '0) ? FILL : DRAIN;
                    end
                end
                DRAIN: begin
                    if (pendingNext == '0) state <= FILL;
                end
                FILL: begin
                    if (sramResult.done) begin
                        fillAddr   <= fillAddr + AW'(1);
                        fillRemain <= fillRemain - AW'(1);
                        if (fillRemain == AW'(1)) begin
                            state     <= IDLE;
                            fill_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign writeOpen  = (state == IDLE);
    assign fillActive = (state == FILL);
`else
    logic unusedFill;

    assign unusedFill = ^{fill_start, fill_base, fill_count, fill_data};
    assign fill_busy  = 1'b0;
    assign writeOpen  = 1'b1;
    assign fillActive = 1'b0;
    assign fillAddr   = '0;
    assign fillData   = '0;
`endif

    // Request is held steady until done; the controller's VGA cycles simply see it unchanged.
    always_comb begin
        sramRequest      = '0;
        sramRequest.we_n = 1'b1;
        sramRequest.oe_n = 1'b1;
        if (fifoHasWord) begin
            sramRequest.address = addrMem[rdPtr];
            sramRequest.dout    = dataMem[rdPtr];
            sramRequest.we_n    = 1'b0;
            sramRequest.den     = 1'b1;
        end else if (fillActive) begin
            sramRequest.address = fillAddr;
            sramRequest.dout    = fillData;
            sramRequest.we_n    = 1'b0;
            sramRequest.den     = 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_write_queue.sv
// Self-checking bench for sram_write_queue: queue-based reference model compared every cycle,
// plus directed literal checks. Fill-engine scenarios are built when SRAM_FILL_EN is defined.
module tb_sram_write_queue;
    import sram_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = SRAM_ADDRESS_WIDTH;
    localparam int DW    = SRAM_DATA_WIDTH;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic          fill_start = 1'b0;
    logic [AW-1:0] fill_base = '0;
    logic [AW-1:0] fill_count = '0;
    logic [DW-1:0] fill_data = '0;
    logic          fill_busy;
    SramRequest_t  sramRequest;
    SramResult_t   sramResult = '0;
    logic [3:0]    pending;
    logic          idle;

    int errors = 0;
    int checks = 0;

    sram_write_queue #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_address(wr_address), .wr_data(wr_data),
        .fill_start(fill_start), .fill_base(fill_base),
        .fill_count(fill_count), .fill_data(fill_data),
        .fill_busy(fill_busy),
        .sramRequest(sramRequest), .sramResult(sramResult),
        .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    // Controller grant: done only on every second cycle, optionally thinned at random.
    bit phase = 1'b0;
    bit doneEn = 1'b0;
    bit doneRand = 1'b0;
    always @(posedge clk) begin
        #1;
        phase = ~phase;
        sramResult.done = doneEn && phase && (!doneRand || ($urandom_range(0, 3) != 0));
        sramResult.din  = DW'($urandom);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus an outstanding fill job.
    word_t         mq[$];
    word_t         wlog[$];
    bit            mBusy = 1'b0;
    logic [AW-1:0] mFillAddr = '0;
    int            mFillRem = 0;
    logic [DW-1:0] mFillData = '0;

    function automatic SramRequest_t expReq();
        SramRequest_t r;
        r = '0;
        r.we_n = 1'b1;
        r.oe_n = 1'b1;
        if (mq.size() != 0) begin
            r.address = mq[0].a;
            r.dout    = mq[0].d;
            r.we_n    = 1'b0;
            r.den     = 1'b1;
        end else if (mBusy) begin
            r.address = mFillAddr;
            r.dout    = mFillData;
            r.we_n    = 1'b0;
            r.den     = 1'b1;
        end
        return r;
    endfunction

    task automatic modelReset();
        mq.delete();
        mBusy    = 1'b0;
        mFillRem = 0;
    endtask

    task automatic modelStep();
        bit busy0;
        bit rdy;
        busy0 = mBusy;
        rdy   = (mq.size() < DEPTH) && !mBusy;
        if (sramResult.done) begin
            if (mq.size() != 0) begin
                wlog.push_back(mq.pop_front());
            end else if (mBusy) begin
                wlog.push_back({mFillAddr, mFillData});
                mFillAddr = mFillAddr + AW'(1);
                mFillRem--;
                if (mFillRem == 0) mBusy = 1'b0;
            end
        end
        if (wr_valid && rdy) mq.push_back({wr_address, wr_data});
`ifdef SRAM_FILL_EN
        if (fill_start && !busy0 && (fill_count != '0)) begin
            mBusy     = 1'b1;
            mFillAddr = fill_base;
            mFillRem  = int'(fill_count);
            mFillData = fill_data;
        end
`else
        if (busy0) mBusy = 1'b0;
`endif
    endtask

    // Inputs change only at posedge+1, so the negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (!rst) modelReset();
        chk("sramRequest", 64'(sramRequest), 64'(expReq()));
        chk("wr_ready", 64'(wr_ready), 64'((mq.size() < DEPTH) && !mBusy));
        chk("pending", 64'(pending), 64'(mq.size()));
        chk("fill_busy", 64'(fill_busy), 64'(mBusy));
        chk("idle", 64'(idle), 64'((mq.size() == 0) && !mBusy));
        if (rst) modelStep();
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit rdy;
        int n;
        n = 0;
        wr_valid   = 1'b1;
        wr_address = a;
        wr_data    = d;
        do begin
            rdy = wr_ready;
            tick(1);
            n++;
        end while (!rdy && n < 200);
        chk("push_handshake", 64'(rdy), 64'(1));
    endtask

    task automatic waitIdle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            ok = idle && !fill_busy;
        end
        chk("idle_timeout", 64'(ok), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        word_t exp[10];

        tick(3);
        rst = 1'b1;
        tick(20);
        chk("reset_we_n", 64'(sramRequest.we_n), 64'(1));
        chk("reset_den", 64'(sramRequest.den), 64'(0));
        chk("reset_wr_ready", 64'(wr_ready), 64'(1));
        chk("reset_idle", 64'(idle), 64'(1));
        chk("reset_pending", 64'(pending), 64'(0));

        // Three back-to-back writes with the controller withholding done.
        doneEn = 1'b0;
        tick(2);
        base = wlog.size();
        wr_valid = 1'b1; wr_address = 18'h00010; wr_data = 16'hAAAA;
        chk("no_issue_in_accept_cycle", 64'(sramRequest.den), 64'(0));
        tick(1);
        chk("pending_1", 64'(pending), 64'(1));
        chk("first_presented", 64'(sramRequest.address), 64'(18'h00010));
        wr_address = 18'h00011; wr_data = 16'h5555;
        tick(1);
        chk("pending_2", 64'(pending), 64'(2));
        wr_address = 18'h00012; wr_data = 16'h1234;
        tick(1);
        chk("pending_3", 64'(pending), 64'(3));
        wr_valid = 1'b0;
        doneEn = 1'b1;
        waitIdle(100);
        chk("three_count", 64'(wlog.size() - base), 64'(3));
        if (wlog.size() - base == 3) begin
            chk("w0", 64'(wlog[base]),     64'({18'h00010, 16'hAAAA}));
            chk("w1", 64'(wlog[base + 1]), 64'({18'h00011, 16'h5555}));
            chk("w2", 64'(wlog[base + 2]), 64'({18'h00012, 16'h1234}));
        end

        // Overfill: FIFO_DEPTH + 2 writes with valid held.
        doneEn = 1'b0;
        tick(2);
        base = wlog.size();
        for (int i = 0; i < 10; i++) exp[i] = {AW'(18'h00100 + i), DW'($urandom)};
        for (int i = 0; i < 8; i++) push(exp[i].a, exp[i].d);
        wr_address = exp[8].a; wr_data = exp[8].d;
        tick(3);
        chk("full_pending", 64'(pending), 64'(8));
        chk("full_not_ready", 64'(wr_ready), 64'(0));
        doneEn = 1'b1;
        push(exp[8].a, exp[8].d);
        push(exp[9].a, exp[9].d);
        wr_valid = 1'b0;
        waitIdle(200);
        chk("overfill_count", 64'(wlog.size() - base), 64'(10));
        if (wlog.size() - base == 10)
            for (int i = 0; i < 10; i++) chk("overfill_order", 64'(wlog[base + i]), 64'(exp[i]));

        // Randomised traffic, including fill commands near the address wrap.
        doneRand = 1'b1;
        for (int c = 0; c < 800; c++) begin
            doneEn     = (c % 100) >= 25;
            wr_valid   = ($urandom_range(0, 2) != 0);
            wr_address = AW'($urandom);
            wr_data    = DW'($urandom);
            fill_start = ($urandom_range(0, 30) == 0);
            fill_base  = ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'(18'h3FFFC + $urandom_range(0, 3));
            fill_count = AW'($urandom_range(0, 5));
            fill_data  = DW'($urandom);
            tick(1);
        end
        wr_valid = 1'b0;
        fill_start = 1'b0;
        doneEn = 1'b1;
        doneRand = 1'b0;
        waitIdle(400);

`ifdef SRAM_FILL_EN
        // Fill behind two queued writes, wrapping through the top of the address space.
        doneEn = 1'b0;
        tick(2);
        base = wlog.size();
        push(18'h00020, 16'h1111);
        push(18'h00021, 16'h2222);
        wr_valid = 1'b0;
        fill_start = 1'b1; fill_base = 18'h3FFFE; fill_count = 18'd4; fill_data = 16'h0020;
        tick(1);
        fill_start = 1'b0;
        chk("fill_busy_rise", 64'(fill_busy), 64'(1));
        chk("fill_blocks_writes", 64'(wr_ready), 64'(0));
        chk("drain_head", 64'(sramRequest.address), 64'(18'h00020));
        doneEn = 1'b1;
        waitIdle(100);
        chk("fill_total", 64'(wlog.size() - base), 64'(6));
        if (wlog.size() - base == 6) begin
            chk("fill_seq0", 64'(wlog[base].a),     64'(18'h00020));
            chk("fill_seq1", 64'(wlog[base + 1].a), 64'(18'h00021));
            chk("fill_seq2", 64'(wlog[base + 2]),   64'({18'h3FFFE, 16'h0020}));
            chk("fill_seq3", 64'(wlog[base + 3]),   64'({18'h3FFFF, 16'h0020}));
            chk("fill_seq4", 64'(wlog[base + 4]),   64'({18'h00000, 16'h0020}));
            chk("fill_seq5", 64'(wlog[base + 5]),   64'({18'h00001, 16'h0020}));
        end

        // Zero-count fill and a fill pulse while busy are both ignored.
        base = wlog.size();
        fill_start = 1'b1; fill_base = 18'h00300; fill_count = 18'd0;
        tick(1);
        fill_start = 1'b0;
        chk("zero_count_busy", 64'(fill_busy), 64'(0));
        tick(6);
        chk("zero_count_writes", 64'(wlog.size() - base), 64'(0));
        doneEn = 1'b0;
        fill_start = 1'b1; fill_base = 18'h00400; fill_count = 18'd2;
        tick(1);
        fill_base = 18'h00500; fill_count = 18'd5;
        tick(1);
        fill_start = 1'b0;
        doneEn = 1'b1;
        waitIdle(100);
        chk("busy_pulse_ignored", 64'(wlog.size() - base), 64'(2));

        // Reset mid-fill with three words outstanding.
        base = wlog.size();
        fill_start = 1'b1; fill_base = 18'h00600; fill_count = 18'd6;
        tick(1);
        fill_start = 1'b0;
        for (int i = 0; i < 100 && wlog.size() < base + 3; i++) tick(1);
        chk("fill_progress", 64'(wlog.size() - base), 64'(3));
        #1 rst = 1'b0;
        #1;
        chk("rst_fill_we_n", 64'(sramRequest.we_n), 64'(1));
        chk("rst_fill_den", 64'(sramRequest.den), 64'(0));
        chk("rst_fill_address", 64'(sramRequest.address), 64'(0));
        chk("rst_fill_pending", 64'(pending), 64'(0));
        chk("rst_fill_busy", 64'(fill_busy), 64'(0));
        tick(3);
        rst = 1'b1;
        tick(20);
        chk("no_stale_fill", 64'(wlog.size() - base), 64'(3));
`else
        base = wlog.size();
        fill_start = 1'b1; fill_base = 18'h00300; fill_count = 18'd4;
        tick(1);
        fill_start = 1'b0;
        chk("fill_disabled_busy", 64'(fill_busy), 64'(0));
        chk("fill_disabled_idle", 64'(idle), 64'(1));
        tick(10);
        chk("fill_disabled_writes", 64'(wlog.size() - base), 64'(0));
`endif

        // Reset with writes queued: everything is discarded at once.
        doneEn = 1'b0;
        tick(2);
        base = wlog.size();
        push(18'h00700, 16'hBEEF);
        push(18'h00701, 16'hCAFE);
        push(18'h00702, 16'hF00D);
        wr_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_q_den", 64'(sramRequest.den), 64'(0));
        chk("rst_q_we_n", 64'(sramRequest.we_n), 64'(1));
        chk("rst_q_pending", 64'(pending), 64'(0));
        tick(3);
        rst = 1'b1;
        doneEn = 1'b1;
        tick(20);
        chk("no_stale_writes", 64'(wlog.size() - base), 64'(0));
        chk("final_idle", 64'(idle), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
